// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared definitions for the RAM march BIST.
//   AW_DEF / DW_DEF : default RAM address / data widths
//   bist_state_t    : controller state encoding
//   pat0 / pat1     : march data patterns, computed at PAT_W bits; callers
//                     truncate to their data width (truncation preserves
//                     all-ones minus address modulo 2^DW)
package ram_bist_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned PAT_W  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_WR1,
    S_RD1,
    S_FLUSH,
    S_FIN
  } bist_state_t;

  function automatic logic [PAT_W-1:0] pat0(input logic [PAT_W-1:0] a);
    return {PAT_W{1'b1}} - a;
  endfunction

  function automatic logic [PAT_W-1:0] pat1(input logic [PAT_W-1:0] a);
    return ~pat0(a);
  endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// ram_bist_chk: read-data compare stage and error bookkeeping.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : clear counters at the start of a new test
//   valid, addr,
//   expected        : compare pipeline register contents (read issued last cycle)
//   rdata           : RAM read data for that read
//   mismatch        : current-cycle compare result (used for the final verdict)
//   err_cnt         : total mismatches this test
//   first_fail_addr : address of the first mismatch, 0 if none
module ram_bist_chk #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          valid,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] expected,
  input  logic [DW-1:0] rdata,
  output logic          mismatch,
  output logic [AW+1:0] err_cnt,
  output logic [AW-1:0] first_fail_addr
);

  assign mismatch = valid && (rdata != expected);

  // At most 2*2^AW reads per test, so AW+2 bits never overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt         <= '0;
      first_fail_addr <= '0;
    end else if (clr) begin
      err_cnt         <= '0;
      first_fail_addr <= '0;
    end else if (mismatch) begin
      err_cnt <= err_cnt + (AW+2)'(1);
      if (err_cnt == '0) first_fail_addr <= addr;
    end
  end

endmodule

// File: rtl/ram_bist.sv
// ram_bist: four-phase march BIST initiator for a single-port RAM.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : run request, honoured only in IDLE
//   mem_ena/mem_wena/mem_addr/mem_wdata : RAM command (registered)
//   mem_rdata       : RAM read data, valid one clock after the read address
//   busy            : test in progress (WR0..FLUSH)
//   done            : one-cycle end-of-test pulse
//   pass            : last completed test had no mismatches
//   err_cnt         : mismatch count of last/current test
//   first_fail_addr : address of first mismatch, 0 if none
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          mem_ena,
  output logic          mem_wena,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_cnt,
  output logic [AW-1:0] first_fail_addr
);

  bist_state_t   state, nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic          pl_valid;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_exp;
  logic          mismatch;
  logic          accept;

  function automatic logic [DW-1:0] pat_at(input logic ph, input logic [AW-1:0] a);
    return ph ? DW'(pat1(PAT_W'(a))) : DW'(pat0(PAT_W'(a)));
  endfunction

  assign accept   = (state == S_IDLE) && start;
  assign mem_addr = addr;

  always_comb begin
    nxt      = state;
    addr_nxt = '0;
    case (state)
      S_IDLE:  if (start) nxt = S_WR0;
      S_WR0: begin
        addr_nxt = addr + AW'(1);
        if (addr == '1) nxt = S_RD0;
      end
      S_RD0: begin
        addr_nxt = addr + AW'(1);
        if (addr == '1) nxt = S_WR1;
      end
      S_WR1: begin
        addr_nxt = addr + AW'(1);
        if (addr == '1) nxt = S_RD1;
      end
      S_RD1: begin
        addr_nxt = addr + AW'(1);
        if (addr == '1) nxt = S_FLUSH;
      end
      S_FLUSH: nxt = S_FIN;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // RAM command and status flags are decoded from the next state so that
  // they are registered yet line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      mem_ena   <= 1'b0;
      mem_wena  <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      pl_valid  <= 1'b0;
      pl_addr   <= '0;
      pl_exp    <= '0;
    end else begin
      state    <= nxt;
      addr     <= addr_nxt;
      mem_ena  <= nxt inside {S_WR0, S_RD0, S_WR1, S_RD1};
      mem_wena <= nxt inside {S_WR0, S_WR1};
      busy     <= nxt inside {S_WR0, S_RD0, S_WR1, S_RD1, S_FLUSH};
      done     <= (nxt == S_FIN);
      if (nxt == S_WR0)      mem_wdata <= pat_at(1'b0, addr_nxt);
      else if (nxt == S_WR1) mem_wdata <= pat_at(1'b1, addr_nxt);
      else                   mem_wdata <= '0;

      pl_valid <= state inside {S_RD0, S_RD1};
      pl_addr  <= addr;
      pl_exp   <= pat_at(state == S_RD1, addr);

      // The final RD1 compare is still in flight when FIN is entered, so
      // the verdict folds in this cycle's mismatch as well.
      if (accept)             pass <= 1'b0;
      else if (nxt == S_FIN)  pass <= (err_cnt == '0) && !mismatch;
    end
  end

  ram_bist_chk #(
    .AW (AW),
    .DW (DW)
  ) u_chk (
    .clk             (clk),
    .rst             (rst),
    .clr             (accept),
    .valid           (pl_valid),
    .addr            (pl_addr),
    .expected        (pl_exp),
    .rdata           (mem_rdata),
    .mismatch        (mismatch),
    .err_cnt         (err_cnt),
    .first_fail_addr (first_fail_addr)
  );

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: scoreboard bench for ram_bist with a faultable RAM model.
module tb_ram_bist;
  import ram_bist_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_ena, mem_wena;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, pass;
  logic [AW+1:0] err_cnt;
  logic [AW-1:0] first_fail_addr;

  ram_bist #(.AW(AW), .DW(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .mem_ena         (mem_ena),
    .mem_wena        (mem_wena),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_fail_addr (first_fail_addr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- fault configuration of the RAM model ----------------
  bit            f_stuck_en;
  logic [AW-1:0] f_stuck_addr;
  int unsigned   f_stuck_bit;
  bit            f_stuck_val;
  logic [AW-1:0] f_alias_mask;   // address bits the faulty decoder ignores

  function automatic logic [AW-1:0] phys(input logic [AW-1:0] a);
    return a & ~f_alias_mask;
  endfunction

  function automatic logic [DW-1:0] stored(input logic [AW-1:0] pa, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (f_stuck_en && pa == f_stuck_addr) r[f_stuck_bit] = f_stuck_val;
    return r;
  endfunction

  task automatic set_fault(input bit en, input int unsigned sa, input int unsigned sb,
                           input bit sv, input int unsigned am);
    f_stuck_en   = en;
    f_stuck_addr = AW'(sa);
    f_stuck_bit  = sb;
    f_stuck_val  = sv;
    f_alias_mask = AW'(am);
  endtask

  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

  always @(posedge clk) begin
    if (mem_ena) begin
      if (mem_wena) ram[phys(mem_addr)] <= stored(phys(mem_addr), mem_wdata);
      else          mem_rdata <= ram[phys(mem_addr)];
    end
  end

  // ---------------- reference model: whole march as array passes --------
  typedef struct {
    int unsigned start_cyc;
    int unsigned err;
    int unsigned ffa;
    bit          pass;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [DW-1:0] pattern(input int unsigned ph, input int unsigned a);
    logic [PAT_W-1:0] w;
    w = (ph == 0) ? pat0(PAT_W'(a)) : pat1(PAT_W'(a));
    return w[DW-1:0];
  endfunction

  function automatic exp_t ref_model(input int unsigned sc);
    logic [DW-1:0] cells [DEPTH];
    exp_t e;
    e.start_cyc = sc;
    e.err = 0;
    e.ffa = 0;
    for (int unsigned ph = 0; ph < 2; ph++) begin
      for (int unsigned a = 0; a < DEPTH; a++)
        cells[phys(AW'(a))] = stored(phys(AW'(a)), pattern(ph, a));
      for (int unsigned a = 0; a < DEPTH; a++)
        if (cells[phys(AW'(a))] != pattern(ph, a)) begin
          if (e.err == 0) e.ffa = a;
          e.err++;
        end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // ---------------- monitor ----------------------------------------------
  int unsigned wcnt = 0, ecnt = 0, wfirst = 0, wlast = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_ena) ecnt++;
      if (mem_wena) begin
        if (wcnt == 0) wfirst = cyc;
        wlast = cyc;
        wcnt++;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_cycle", cyc, mon_e.start_cyc + 130);
          chk("err_cnt", err_cnt, mon_e.err);
          chk("first_fail_addr", first_fail_addr, mon_e.ffa);
          chk("pass", pass, mon_e.pass);
          chk("busy_at_done", busy, 0);
          chk("wena_cycles", wcnt, 64);
          chk("wena_first", wfirst, mon_e.start_cyc + 1);
          chk("wena_last", wlast, mon_e.start_cyc + 96);
          chk("ena_cycles", ecnt, 128);
        end
        wcnt = 0; ecnt = 0;
      end else if (!busy) begin
        wcnt = 0; ecnt = 0;
      end
    end
  end

  // ---------------- driver -----------------------------------------------
  function automatic logic [63:0] outs();
    return {mem_ena, mem_wena, mem_addr, mem_wdata, busy, done, pass, err_cnt, first_fail_addr};
  endfunction

  task automatic issue(output int unsigned sc);
    sc = cyc;
    sbq.push_back(ref_model(sc));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 1, 0);
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned sc;
    exp_t e;
    start = 1'b0;
    rst   = 1'b1;
    mem_rdata = '0;
    set_fault(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // fault-free, with a stray start pulse while busy
    issue(sc);
    while (cyc != sc + 50) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // bit0 stuck-at-0 at address 5
    set_fault(1, 5, 0, 0, 0);
    issue(sc);
    wait_idle();

    // decoder ignores addr[4]
    set_fault(0, 0, 0, 0, 16);
    issue(sc);
    wait_idle();

    // start held high across two runs; counters cleared at each acceptance
    sc = cyc;
    e = ref_model(sc);
    sbq.push_back(e);
    e.start_cyc = sc + 131;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    chk("err_clr_first", err_cnt, 0);
    while (cyc != sc + 132) @(negedge clk);
    chk("err_clr_second", err_cnt, 0);
    start = 1'b0;
    wait_idle();

    // reset during RD0 at address 10
    set_fault(0, 0, 0, 0, 0);
    issue(sc);
    while (cyc != sc + 43) @(negedge clk);
    chk("abort_addr", mem_addr, 10);
    chk("abort_is_read", {mem_ena, mem_wena}, 2'b10);
    #1 rst = 1'b1;
    #1 chk("abort_outputs", outs(), 0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after_abort", {busy, mem_ena, done}, 0);
    issue(sc);
    wait_idle();

    // randomized fault configurations
    for (int r = 0; r < 6; r++) begin
      set_fault($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, DW - 1),
                $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0) ? (1 << $urandom_range(0, AW - 1)) : 0);
      issue(sc);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator that drives the single-port 32x32 RAM through its clk/ena/wena/addr/data_in/data_out interface.
- One `start` pulse runs a fixed four-phase march:
  - write pattern,
  - read/compare,
  - write complement,
  - read/compare.
- Reports pass/fail, mismatch count and first failing address.
- Sits between the top-level control logic and the RAM. Replaces manual bench stimulus for power-on memory checking.

Parameters:
- AW, 5, RAM address width; depth = 2^AW.
- DW, 32, RAM data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- mem_ena  output  1  RAM enable.
- mem_wena  output  1  RAM write enable: 1 = write, 0 = read.
- mem_addr  output  AW  RAM address.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM read data; valid one clock after the read address is presented.
- busy  output  1  test in progress.
- done  output  1  one-cycle pulse at end of test.
- pass  output  1  result of last completed test; 1 = no mismatches.
- err_cnt  output  AW+2  total mismatches in last/current test.
- first_fail_addr  output  AW  address of first mismatch; 0 if none.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous, active-high.
- Reset (async, immediate): state IDLE; addr counter 0; compare pipeline cleared.
  - All outputs 0: mem_ena, mem_wena, mem_addr, mem_wdata, busy, done, pass, err_cnt, first_fail_addr.
- Patterns:
  - P0(a) = {DW{1'b1}} - a (zero-extended a), i.e. FFFFFFFF, FFFFFFFE, ...
  - P1(a) = ~P0(a).
- States: IDLE, WR0, RD0, WR1, RD1, FLUSH, FIN.
- IDLE: when start=1, go to WR0 with addr=0; clear err_cnt, first_fail_addr and pass. Otherwise stay.
- WR0 / WR1:
  - mem_ena=1, mem_wena=1, mem_addr=addr, mem_wdata=P0(addr) (WR0) or P1(addr) (WR1).
  - addr increments each cycle. At addr = 2^AW-1, wrap to 0 and advance to the next state.
- RD0 / RD1:
  - mem_ena=1, mem_wena=0, mem_wdata=0.
  - Each cycle, load the compare pipeline register with {valid=1, addr, expected=P0/P1(addr)}.
  - Same wrap/advance rule as the write states.
  - RD0 → WR1; RD1 → FLUSH.
- Compare: in the cycle after each pipeline load, compare mem_rdata with expected.
  - On mismatch: err_cnt += 1 (cannot overflow; max 2^(AW+1)).
  - If this is the first mismatch: first_fail_addr = pipeline addr.
  - The compare runs independently of state, so the last RD0 compare lands in the first WR1 cycle.
- FLUSH:
  - mem_ena=0, busy=1; compares the final RD1 read. Next state: FIN.
- FIN:
  - done=1 for exactly one cycle; busy=0; pass = (err_cnt==0), including the FLUSH compare result. Next state: IDLE.
- busy: 1 in WR0..FLUSH, 0 in IDLE/FIN.
- pass, err_cnt, first_fail_addr: hold until the next accepted start.
- start outside IDLE: ignored. start held high: the next run begins from the IDLE cycle after FIN.
- Timing: start sampled at cycle 0 → WR0 cycles 1..32, RD0 33..64, WR1 65..96, RD1 97..128, FLUSH 129, FIN (done) 130, IDLE 131.
- Outputs come from registered state/counter only; there is no combinational path from start or mem_rdata to any output.
- Reset mid-run aborts immediately with no completion pulse. The RAM contents are left undefined.

Decomposition:
- Shared header/package holds: state encoding localparams (IDLE..FIN), AW/DW defaults, and the P0/P1 pattern functions, so the bench golden model reuses the same patterns.
- No sub-module required. The compare pipeline plus error bookkeeping may be split into ram_bist_chk (inputs: valid, addr, expected, rdata; outputs: err_cnt, first_fail_addr) if that aids reuse.

Test Plan:
- Fault-free RAM model, start pulse at cycle 0:
  - mem_wena=1 during cycles 1..32 and 65..96.
  - done pulse at cycle 130; pass=1, err_cnt=0, first_fail_addr=0.
- RAM model with bit0 stuck-at-0 at address 5:
  - P0(5)=FFFFFFFA passes; P1(5)=00000005 fails in RD1.
  - Result: pass=0, err_cnt=1, first_fail_addr=5.
- RAM model ignoring addr[4] (aliasing):
  - Addresses 0..15 mismatch in both RD0 and RD1.
  - Result: err_cnt=32, first_fail_addr=0, pass=0.
- Assert rst while in RD0 at addr=10:
  - Same cycle: all outputs 0, mem_ena=0; no done pulse.
  - After release: stays IDLE until start; the rerun passes.
- start pulsed again at cycle 50 (busy): ignored, done still at cycle 130.
- start held high: done pulses at cycles 130 and 261; err_cnt cleared at each accepted start.
